// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, default word size and the
// receiver state encoding. The transmitter will import the same package.
package uart_pkg;

  localparam int OVERSAMPLE    = 16;
  localparam int DEFAULT_DBITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: oversample strobe and serial line in, received
// word, completion pulse and stop-bit status out.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DBITS = DEFAULT_DBITS
);

  logic             s_tick;
  logic             rx;
  logic [DBITS-1:0] dout;
  logic             rx_done_tick;
  logic             frame_err;

  // Line/strobe driver side (baud generator plus transceiver pin).
  modport master (
    output s_tick,
    output rx,
    input  dout,
    input  rx_done_tick,
    input  frame_err
  );

  // Receiver side.
  modport slave (
    input  s_tick,
    input  rx,
    output dout,
    output rx_done_tick,
    output frame_err
  );

endinterface : uart_rx_if

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit. The reset value is a
// parameter so idle-high lines do not show a false edge leaving reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: plain two-stage shift of the incoming bit.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// UART receiver driven by an external x16 oversample strobe. Start bit is
// validated at its middle, data bits are sampled mid-bit LSB first, and the
// stop bit is sampled SB_TICK ticks after the last data bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBITS   = DEFAULT_DBITS,
  parameter int SB_TICK = OVERSAMPLE
) (
  input  logic     clk,
  input  logic     reset_n,
  uart_rx_if.slave bus
);

  // Two stop bits need a 5-bit oversample counter.
  localparam int SW = (SB_TICK > OVERSAMPLE) ? 5 : 4;
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBITS - 1);

  rx_state_e        state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [2:0]       n_q, n_d;
  logic [DBITS-1:0] b_q, b_d;
  logic [DBITS-1:0] dout_q, dout_d;
  logic             frame_err_q, frame_err_d;
  logic             done_q, done_d;
  logic             rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.rx),
    .q       (rx_s)
  );

  // Next-state and datapath: everything except start detection waits for s_tick.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    b_d         = b_q;
    dout_d      = dout_q;
    frame_err_d = frame_err_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_q == S_MID) begin
            s_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              n_d     = 3'd0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBITS-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (s_q == S_STOP) begin
            state_d     = IDLE;
            s_d         = '0;
            dout_d      = b_q;
            frame_err_d = ~rx_s;
            done_d      = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
        n_d     = 3'd0;
      end
    endcase
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= 3'd0;
      b_q         <= '0;
      dout_q      <= '0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      b_q         <= b_d;
      dout_q      <= dout_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.rx_done_tick = done_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// checked against a queue of expected (data, stop-bit) records.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DBITS = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
  } frame_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick_en = 1'b1;

  uart_rx_if #(.DBITS(DBITS)) bus ();

  uart_rx #(.DBITS(DBITS), .SB_TICK(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     pulse_cnt = 0;
  frame_t exp_q[$];
  frame_t mon_f;
  logic [7:0] model_dout = 8'h00;
  logic       model_ferr = 1'b0;
  logic       tick_at_edge = 1'b0;
  logic       prev_done = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // x16 strobe: one clk pulse every 4 clk while enabled
  initial begin
    int c;
    c = 0;
    bus.s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        c = (c + 1) % 4;
        bus.s_tick = (c == 0);
      end else begin
        bus.s_tick = 1'b0;
      end
    end
  end

  // record the strobe value the DUT samples at each edge
  always @(posedge clk) tick_at_edge = bus.s_tick;

  // completion monitor: pulse timing, width and content against the expected queue
  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) begin
      pulse_cnt++;
      check_val("done_follows_tick", tick_at_edge, 1);
      check_val("done_single_cycle", prev_done, 0);
      if (exp_q.size() == 0) begin
        check_val("unexpected_pulse", 1, 0);
      end else begin
        mon_f = exp_q.pop_front();
        check_val("dout", bus.dout, mon_f.data);
        check_val("frame_err", bus.frame_err, mon_f.ferr);
        model_dout = mon_f.data;
        model_ferr = mon_f.ferr;
      end
    end
    prev_done = bus.rx_done_tick;
  end

  // wait for k sampled strobes, bounded
  task automatic wait_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      int g;
      g = 0;
      do begin
        @(posedge clk);
        g++;
      end while (!bus.s_tick && g < 2000);
      if (g >= 2000) check_val("tick_timeout", 0, 1);
    end
  endtask

  task automatic idle_ticks(input int k);
    bus.rx = 1'b1;
    wait_ticks(k);
    #2;
  endtask

  // one frame, 16 ticks per bit; optional tick stall or reset abort in bit i
  task automatic send_frame(input logic [7:0] data, input bit stop_low,
                            input int stall_bit, input int abort_bit);
    frame_t f;
    logic   v;
    f.data = data;
    f.ferr = stop_low;
    exp_q.push_back(f);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) v = 1'b0;
      else if (i == 9) v = ~stop_low;
      else v = data[i-1];
      bus.rx = v;
      if (i == abort_bit) begin
        wait_ticks(8);
        #2 reset_n = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        bus.rx = 1'b1;
        void'(exp_q.pop_back());
        model_dout = 8'h00;
        model_ferr = 1'b0;
        return;
      end
      if (i == stall_bit) begin
        wait_ticks(8);
        tick_en = 1'b0;
        repeat (1000) @(posedge clk);
        tick_en = 1'b1;
        wait_ticks(8);
      end else if (i == 9 && stop_low) begin
        wait_ticks(10);
        #2 bus.rx = 1'b1;
        wait_ticks(6);
      end else begin
        wait_ticks(16);
      end
      #2;
    end
  endtask

  task automatic check_settled(input string tag, input int exp_pulses);
    check_val({tag, "_pulses"}, pulse_cnt, exp_pulses);
    check_val({tag, "_pending"}, exp_q.size(), 0);
    check_val({tag, "_dout_hold"}, bus.dout, model_dout);
    check_val({tag, "_ferr_hold"}, bus.frame_err, model_ferr);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int npulse;
    int gap;
    bit sl;
    bus.rx = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check_val("reset_dout", bus.dout, 0);
    check_val("reset_ferr", bus.frame_err, 0);
    check_val("reset_done", bus.rx_done_tick, 0);
    idle_ticks(20);

    // basic frame
    send_frame(8'hA5, 1'b0, -1, -1);
    idle_ticks(24);
    npulse = 1;
    check_settled("a5", npulse);
    check_val("a5_dout", bus.dout, 8'hA5);
    check_val("a5_ferr", bus.frame_err, 0);

    // short start glitch is rejected
    bus.rx = 1'b0;
    wait_ticks(3);
    #2 bus.rx = 1'b1;
    idle_ticks(24);
    check_settled("glitch", npulse);
    check_val("glitch_dout", bus.dout, 8'hA5);

    // low stop bit
    send_frame(8'h3C, 1'b1, -1, -1);
    idle_ticks(24);
    npulse++;
    check_settled("ferr", npulse);
    check_val("ferr_dout", bus.dout, 8'h3C);
    check_val("ferr_flag", bus.frame_err, 1);

    // back-to-back frames
    send_frame(8'h00, 1'b0, -1, -1);
    send_frame(8'hFF, 1'b0, -1, -1);
    idle_ticks(24);
    npulse += 2;
    check_settled("b2b", npulse);
    check_val("b2b_dout", bus.dout, 8'hFF);
    check_val("b2b_ferr", bus.frame_err, 0);

    // reset in data bit 4 aborts the frame
    send_frame(8'h81, 1'b0, -1, 5);
    idle_ticks(16 * 12);
    check_settled("abort", npulse);
    check_val("abort_dout", bus.dout, 0);
    check_val("abort_ferr", bus.frame_err, 0);
    send_frame(8'h81, 1'b0, -1, -1);
    idle_ticks(24);
    npulse++;
    check_settled("after_abort", npulse);
    check_val("after_abort_dout", bus.dout, 8'h81);

    // strobe stalled mid data
    send_frame(8'h6B, 1'b0, 4, -1);
    idle_ticks(24);
    npulse++;
    check_settled("stall", npulse);
    check_val("stall_dout", bus.dout, 8'h6B);

    // random frames, gaps and stop-bit errors
    for (int k = 0; k < 30; k++) begin
      sl = ($urandom_range(0, 4) == 0);
      send_frame(8'($urandom_range(0, 255)), sl, -1, -1);
      npulse++;
      gap = sl ? 16 + $urandom_range(0, 16) : $urandom_range(0, 20);
      if (gap > 0) idle_ticks(gap);
    end
    idle_ticks(32);
    check_settled("random", npulse);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBITS, default 8, number of data bits per frame; legal range 5..8.
REQ-002 Parameter SB_TICK, default 16, stop-bit length in oversample ticks; 16 = 1 stop bit, 32 = 2.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 s_tick  input  1  x16 oversample strobe from the baud generator; one-clk pulse per 1/16 bit period.
REQ-006 rx  input  1  serial line, asynchronous to clk; idle high.
REQ-007 dout  output  DBITS  last received data word.
REQ-008 rx_done_tick  output  1  one-clk pulse when a frame completes.
REQ-009 frame_err  output  1  stop-bit status of the last completed frame; 1 = stop bit sampled low.

Function
REQ-010 rx SHALL pass a 2-flop synchronizer (flops reset to 1) before any use; rx_s denotes the synchronized value.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP; oversample counter s is 4 bits (5 bits if SB_TICK > 16); bit counter n is 3 bits.
REQ-012 s, n and the state SHALL change only in cycles where s_tick = 1, except the IDLE->START transition.
REQ-013 IDLE: rx_s = 0 -> START with s = 0, independent of s_tick; otherwise stay.
REQ-014 START: on s_tick with s = 7 (mid start bit), rx_s = 0 -> DATA with s = 0, n = 0; rx_s = 1 -> IDLE (glitch rejection, no outputs change); otherwise s increments.
REQ-015 DATA: on s_tick with s = 15, shift register b = {rx_s, b[DBITS-1:1]} (LSB first), s = 0; if n = DBITS-1 -> STOP, else n increments; otherwise s increments.
REQ-016 STOP: on s_tick with s = SB_TICK-1, load dout = b, frame_err = ~rx_s, assert rx_done_tick for one cycle, go to IDLE; otherwise s increments.
REQ-017 rx_done_tick SHALL be high in exactly the clk cycle following the terminating s_tick, and low in all other cycles.
REQ-018 dout and frame_err SHALL change only when rx_done_tick asserts and hold their values otherwise.
REQ-019 A frame with a low stop bit SHALL still update dout and pulse rx_done_tick, with frame_err = 1.
REQ-020 A start bit immediately following STOP->IDLE SHALL be accepted; no dead cycles beyond the IDLE detection cycle.
REQ-021 If s_tick stays low, the FSM SHALL freeze in its current state indefinitely.

Reset
REQ-022 On the clk edge with reset_n = 0: state = IDLE, s = 0, n = 0, b = 0, dout = 0, rx_done_tick = 0, frame_err = 0, synchronizer flops = 1.
REQ-023 Reset during any non-IDLE state SHALL abort the frame with no rx_done_tick pulse and no dout update.

Structure
REQ-024 Package uart_pkg SHALL hold the rx state enum, OVERSAMPLE = 16 and DEFAULT_DBITS = 8; the future transmitter shares it.
REQ-025 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset value parameter), reusable by other blocks.
REQ-026 uart_rx SHALL contain no baud divider; s_tick is supplied by the existing x16 baud generator output.

Verification
REQ-027 s_tick every 4 clk; send 0xA5 with 1 stop bit at 64 clk/bit -> exactly one rx_done_tick, dout = 0xA5, frame_err = 0.
REQ-028 rx low for 3 s_tick periods then high -> FSM returns to IDLE, no rx_done_tick, dout unchanged.
REQ-029 Send 0x3C with the stop bit driven low -> rx_done_tick pulses, dout = 0x3C, frame_err = 1.
REQ-030 Back-to-back frames 0x00 then 0xFF with no idle gap -> two pulses, dout = 0x00 then 0xFF, frame_err = 0 both times.
REQ-031 reset_n low for 1 clk during bit 4 of frame 0x81 -> no pulse, dout = 0, next full frame 0x81 received correctly.
REQ-032 s_tick held low for 1000 clk mid DATA, then resumed -> frame completes with the correct byte once ticks resume.
